// File: rtl/outport.sv
// outport: router output port; round-robin grant per packet, credit-gated flit send.
// Optional feature macro: OUTPORT_CREDIT_CHK_EN (adds sticky credit_err overflow flag).
module outport #(
    parameter int PORTS        = 5,
    parameter int PKT_FLITS    = 4,
    parameter int BUFFER_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [PORTS-1:0]    port_rqs,
    input  logic [PORTS*32-1:0] channels_in,
    input  logic                crt_in,
    output logic [PORTS-1:0]    arb_ack,
    output logic [PORTS-1:0]    rd_strobe,
    output logic [31:0]         output_channel,
    output logic                diff_pair_p,
    output logic                diff_pair_n,
`ifdef OUTPORT_CREDIT_CHK_EN
    output logic                busy,
    output logic                credit_err
`else
    output logic                busy
`endif
);

    localparam int IW = (PORTS > 1) ? $clog2(PORTS) : 1;
    localparam int FW = $clog2(PKT_FLITS + 1);
    localparam int CW = $clog2(BUFFER_DEPTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_GRANT,
        S_SEND
    } state_t;

    state_t         state_q, state_d;
    logic [IW-1:0]  win_q, win_d;
    logic [IW-1:0]  rr_q, rr_d;
    logic [FW-1:0]  issued_q, issued_d;
    logic [CW-1:0]  credits_q, credits_d;
    logic           link_q, link_d;
    logic [31:0]    hold_q, hold_d;

    logic           pick_found;
    logic [IW-1:0]  pick_idx;
    logic [PORTS-1:0] win_oh;
    logic           issue;
    logic           cred_full;
    logic [31:0]    slice;

    assign win_oh    = PORTS'(1) << win_q;
    assign cred_full = (credits_q == CW'(BUFFER_DEPTH));
    assign slice     = channels_in[32*int'(win_q) +: 32];

    // Round-robin search: first requester at or above rr_q, wrapping.
    always_comb begin
        int cand;
        cand       = 0;
        pick_found = 1'b0;
        pick_idx   = rr_q;
        for (int i = 0; i < PORTS; i++) begin
            cand = (int'(rr_q) + i) % PORTS;
            if (!pick_found && port_rqs[cand]) begin
                pick_found = 1'b1;
                pick_idx   = IW'(cand);
            end
        end
    end

    // Packet FSM: grant hold, credit-gated reads, completion and pointer advance.
    always_comb begin
        state_d   = state_q;
        win_d     = win_q;
        rr_d      = rr_q;
        issued_d  = issued_q;
        arb_ack   = '0;
        rd_strobe = '0;
        issue     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (pick_found) begin
                    win_d   = pick_idx;
                    state_d = S_GRANT;
                end
            end
            S_GRANT: begin
                arb_ack  = win_oh;
                issued_d = '0;
                state_d  = S_SEND;
            end
            S_SEND: begin
                arb_ack = win_oh;
                if (issued_q < FW'(PKT_FLITS) && credits_q != '0) begin
                    issue     = 1'b1;
                    rd_strobe = win_oh;
                    issued_d  = issued_q + FW'(1);
                end
                if (issued_q == FW'(PKT_FLITS)) begin
                    state_d = S_IDLE;
                    rr_d    = (win_q == IW'(PORTS - 1)) ? '0 : win_q + IW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Credit count: spend on read, refund on crt_in, saturate at depth.
    always_comb begin
        credits_d = credits_q;
        unique case ({issue, crt_in})
            2'b10:   credits_d = credits_q - CW'(1);
            2'b01:   if (!cred_full) credits_d = credits_q + CW'(1);
            default: credits_d = credits_q;
        endcase
    end

    // Link stage: FIFO data arrives the cycle after the read pulse.
    always_comb begin
        link_d = issue;
        hold_d = link_q ? slice : hold_q;
    end

    assign output_channel = link_q ? slice : hold_q;
    assign diff_pair_p    = link_q;
    assign diff_pair_n    = ~link_q;
    assign busy           = (state_q != S_IDLE);

    // State registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            win_q     <= '0;
            rr_q      <= '0;
            issued_q  <= '0;
            credits_q <= CW'(BUFFER_DEPTH);
            link_q    <= 1'b0;
            hold_q    <= '0;
        end else begin
            state_q   <= state_d;
            win_q     <= win_d;
            rr_q      <= rr_d;
            issued_q  <= issued_d;
            credits_q <= credits_d;
            link_q    <= link_d;
            hold_q    <= hold_d;
        end
    end

`ifdef OUTPORT_CREDIT_CHK_EN
    logic err_q, err_d;

    // Sticky flag: refund arriving while already full and not spending.
    always_comb begin
        err_d = err_q | (crt_in & cred_full & ~issue);
    end

    // Overflow flag register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign credit_err = err_q;
`endif

endmodule

// File: tb/tb_outport.sv
// tb_outport: random + directed stimulus against a behavioural outport model.
// Build with or without OUTPORT_CREDIT_CHK_EN.
module tb_outport;

    localparam int PORTS = 5;
    localparam int PKT   = 4;
    localparam int DEPTH = 4;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic [PORTS-1:0]    port_rqs = '0;
    logic [PORTS*32-1:0] channels_in;
    logic                crt_in = 1'b0;
    logic [PORTS-1:0]    arb_ack;
    logic [PORTS-1:0]    rd_strobe;
    logic [31:0]         output_channel;
    logic                diff_pair_p;
    logic                diff_pair_n;
    logic                busy;
`ifdef OUTPORT_CREDIT_CHK_EN
    logic                credit_err;
`endif

    outport #(.PORTS(PORTS), .PKT_FLITS(PKT), .BUFFER_DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .port_rqs       (port_rqs),
        .channels_in    (channels_in),
        .crt_in         (crt_in),
        .arb_ack        (arb_ack),
        .rd_strobe      (rd_strobe),
        .output_channel (output_channel),
        .diff_pair_p    (diff_pair_p),
        .diff_pair_n    (diff_pair_n),
`ifdef OUTPORT_CREDIT_CHK_EN
        .busy           (busy),
        .credit_err     (credit_err)
`else
        .busy           (busy)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cmode = 0;
    int occ = 0;
    int cyc = 0;
    int rd_cnt = 0;
    int arb2_cyc = 0;
    logic [PORTS-1:0] rd_seen = '0;
    logic [PORTS-1:0] prev_arb = '0;
    logic [31:0] mem [PORTS][256];
    int ptr [PORTS];
    int grant_q[$];
    int grant_cyc[$];
    logic [31:0] link_q[$];

    int m_phase = 0, m_win = 0, m_rr = 0, m_issued = 0, m_cred = DEPTH;
    bit m_link = 0, m_err = 0;
    logic [31:0] m_pend = '0, m_out = '0;
    int m_idx [PORTS];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic int oh2i(input logic [PORTS-1:0] v);
        int r = -1;
        for (int i = 0; i < PORTS; i++) if (v[i]) r = i;
        return r;
    endfunction

    function automatic logic [PORTS-1:0] oh(input int i);
        logic [PORTS-1:0] v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    function automatic int gq(input int i);
        return (i < grant_q.size()) ? grant_q[i] : -1;
    endfunction

    function automatic int gc(input int i);
        return (i < grant_cyc.size()) ? grant_cyc[i] : -1;
    endfunction

    function automatic logic [31:0] lq(input int i);
        return (i < link_q.size()) ? link_q[i] : 32'hFFFF_FFFF;
    endfunction

    // Inport FIFO stand-in and downstream credit return.
    always @(posedge clk) begin
        #1;
        for (int p = 0; p < PORTS; p++) begin
            if (rd_seen[p]) begin
                channels_in[32*p +: 32] = mem[p][ptr[p]];
                ptr[p] = (ptr[p] + 1) % 256;
            end
        end
        if (cmode != 2) occ = 0;
        if (cmode == 1) begin
            crt_in = |rd_seen;
        end else if (cmode == 2) begin
            if (rd_seen != '0) occ++;
            crt_in = 1'b0;
            if (occ > 0 && $urandom_range(0, 2) == 0) begin
                crt_in = 1'b1;
                occ--;
            end
        end
    end

    // Reference model and per-cycle compare.
    always @(negedge clk) begin
        logic [PORTS-1:0] e_arb, e_rd;
        int c;
        bit fnd;
        if (!rst) begin
            m_phase = 0; m_win = 0; m_rr = 0; m_issued = 0;
            m_cred = DEPTH; m_link = 0; m_out = '0; m_err = 0;
            rd_seen = '0;
            chk("rst_arb_ack", 64'(arb_ack), 64'd0);
            chk("rst_rd_strobe", 64'(rd_strobe), 64'd0);
            chk("rst_output_channel", 64'(output_channel), 64'd0);
            chk("rst_diff_p", 64'(diff_pair_p), 64'd0);
            chk("rst_diff_n", 64'(diff_pair_n), 64'd1);
            chk("rst_busy", 64'(busy), 64'd0);
`ifdef OUTPORT_CREDIT_CHK_EN
            chk("rst_credit_err", 64'(credit_err), 64'd0);
`endif
        end else begin
            e_arb = (m_phase != 0) ? oh(m_win) : '0;
            e_rd  = (m_phase == 2 && m_issued < PKT && m_cred > 0) ? oh(m_win) : '0;
            if (m_link) m_out = m_pend;
            chk("arb_ack", 64'(arb_ack), 64'(e_arb));
            chk("rd_strobe", 64'(rd_strobe), 64'(e_rd));
            chk("diff_p", 64'(diff_pair_p), 64'(m_link));
            chk("diff_n", 64'(diff_pair_n), 64'(!m_link));
            chk("output_channel", 64'(output_channel), 64'(m_out));
            chk("busy", 64'(busy), 64'(m_phase != 0));
`ifdef OUTPORT_CREDIT_CHK_EN
            chk("credit_err", 64'(credit_err), 64'(m_err));
`endif
            rd_seen = rd_strobe;
            if (arb_ack != '0 && prev_arb == '0) begin
                grant_q.push_back(oh2i(arb_ack));
                grant_cyc.push_back(cyc);
            end
            if (diff_pair_p) link_q.push_back(output_channel);
            if (rd_strobe != '0) rd_cnt++;
            if (arb_ack == 5'b00100) arb2_cyc++;

            if (e_rd != '0) begin
                m_pend = mem[m_win][m_idx[m_win]];
                m_idx[m_win] = (m_idx[m_win] + 1) % 256;
            end
            m_link = (e_rd != '0);
            if (crt_in) begin
                if (m_cred == DEPTH && e_rd == '0) m_err = 1;
                else m_cred++;
            end
            if (e_rd != '0) m_cred--;
            case (m_phase)
                0: begin
                    if (port_rqs != '0) begin
                        fnd = 0;
                        for (int k = 0; k < PORTS; k++) begin
                            c = (m_rr + k) % PORTS;
                            if (!fnd && port_rqs[c]) begin
                                fnd = 1;
                                m_win = c;
                            end
                        end
                        m_phase = 1;
                    end
                end
                1: begin
                    m_phase = 2;
                    m_issued = 0;
                end
                default: begin
                    if (m_issued == PKT) begin
                        m_phase = 0;
                        m_rr = (m_win + 1) % PORTS;
                    end else if (e_rd != '0) begin
                        m_issued++;
                    end
                end
            endcase
        end
        prev_arb = rst ? arb_ack : '0;
        cyc++;
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_grant(input int maxc);
        int n = 0;
        while (arb_ack == '0 && n < maxc) begin
            tick();
            n++;
        end
        chk("grant_timeout", 64'(arb_ack != '0), 64'd1);
    endtask

    task automatic wait_idle(input int maxc);
        int n = 0;
        while (busy && n < maxc) begin
            tick();
            n++;
        end
        chk("idle_timeout", 64'(busy), 64'd0);
    endtask

    task automatic pulse_crt(input int n);
        repeat (n) begin
            crt_in = 1'b1;
            tick();
            crt_in = 1'b0;
            tick();
        end
    endtask

    initial begin
        #1_000_000;
        failures++;
        $display("FAIL watchdog actual=running expected=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

    initial begin
        int base;
        logic [PORTS-1:0] req;
        for (int p = 0; p < PORTS; p++) begin
            ptr[p] = 0;
            m_idx[p] = 0;
            channels_in[32*p +: 32] = 32'hDEAD_0000 + 32'(p);
            for (int i = 0; i < 256; i++) mem[p][i] = $urandom;
        end
        for (int i = 0; i < 4; i++) mem[2][i] = 32'hA100_0001 + 32'(i);

        // Reset with every port requesting.
        rst = 1'b0;
        port_rqs = 5'b11111;
        tick(3);
        chk("reset_diff_n_literal", 64'(diff_pair_n), 64'd1);

        // Single packet on port 2.
        port_rqs = 5'b00100;
        rst = 1'b1;
        arb2_cyc = 0;
        rd_cnt = 0;
        link_q.delete();
        wait_grant(10);
        port_rqs = '0;
        wait_idle(20);
        chk("single_arb_cycles", 64'(arb2_cyc), 64'd6);
        chk("single_rd_pulses", 64'(rd_cnt), 64'd4);
        for (int i = 0; i < 4; i++)
            chk("single_flit", 64'(lq(i)), 64'(32'hA100_0001 + 32'(i)));
        pulse_crt(4);

        // Pointer now past port 2: port 3 beats port 0.
        grant_q.delete();
        port_rqs = 5'b01001;
        wait_grant(10);
        port_rqs = '0;
        wait_idle(20);
        chk("rr_after_port2", 64'(gq(0)), 64'd3);

        // Round-robin between ports 0 and 4 from a fresh pointer.
        rst = 1'b0;
        tick(2);
        rst = 1'b1;
        cmode = 1;
        grant_q.delete();
        grant_cyc.delete();
        port_rqs = 5'b10001;
        base = 0;
        while (grant_q.size() < 3 && base < 60) begin
            tick();
            base++;
        end
        port_rqs = '0;
        wait_idle(30);
        tick(2);
        cmode = 0;
        crt_in = 1'b0;
        tick();
        chk("rr_grant0", 64'(gq(0)), 64'd0);
        chk("rr_grant1", 64'(gq(1)), 64'd4);
        chk("rr_grant2", 64'(gq(2)), 64'd0);
        chk("rr_gap1", 64'(gc(1) - gc(0)), 64'd7);
        chk("rr_gap2", 64'(gc(2) - gc(1)), 64'd7);

        // Refund at full credit: saturates (flagged when the check is built in).
        pulse_crt(1);
`ifdef OUTPORT_CREDIT_CHK_EN
        chk("overflow_flag", 64'(credit_err), 64'd1);
`endif

        // Credit stall: two packets, no refunds.
        grant_q.delete();
        port_rqs = 5'b00011;
        base = 0;
        while (grant_q.size() < 2 && base < 40) begin
            tick();
            base++;
        end
        port_rqs = '0;
        chk("stall_order0", 64'(gq(0)), 64'd1);
        chk("stall_order1", 64'(gq(1)), 64'd0);
        base = rd_cnt;
        tick(8);
        chk("stall_no_strobe", 64'(rd_cnt - base), 64'd0);
        chk("stall_hold_ack", 64'(arb_ack), 64'(5'b00001));
        base = rd_cnt;
        pulse_crt(1);
        tick(4);
        chk("one_credit_one_flit", 64'(rd_cnt - base), 64'd1);

        // Refund coinciding with a read at one credit.
        crt_in = 1'b1;
        tick();
        chk("simul_first", 64'(rd_strobe), 64'(5'b00001));
        tick();
        chk("simul_continue", 64'(rd_strobe), 64'(5'b00001));
        crt_in = 1'b0;
        tick();
        chk("simul_drained", 64'(rd_strobe), 64'd0);
        pulse_crt(1);
        wait_idle(20);
        pulse_crt(4);

        // Reset after the second flit, then a full packet.
        cmode = 1;
        port_rqs = 5'b00100;
        wait_grant(10);
        base = rd_cnt;
        while (rd_cnt < base + 2 && rd_cnt < base + 100) tick();
        rst = 1'b0;
        #1;
        chk("midrst_arb", 64'(arb_ack), 64'd0);
        chk("midrst_rd", 64'(rd_strobe), 64'd0);
        chk("midrst_out", 64'(output_channel), 64'd0);
        chk("midrst_n", 64'(diff_pair_n), 64'd1);
        tick(2);
        rst = 1'b1;
        link_q.delete();
        wait_grant(10);
        port_rqs = '0;
        wait_idle(20);
        chk("midrst_full_packet", 64'(link_q.size()), 64'd4);
        tick(2);

        // Random traffic with random credit return.
        cmode = 2;
        req = '0;
        for (int t = 0; t < 400; t++) begin
            for (int p = 0; p < PORTS; p++) begin
                if (arb_ack[p]) req[p] = 1'b0;
                else if (!req[p] && $urandom_range(0, 5) == 0) req[p] = 1'b1;
                else if (req[p] && $urandom_range(0, 40) == 0) req[p] = 1'b0;
            end
            port_rqs = req;
            tick();
        end
        port_rqs = '0;
        wait_idle(300);
        tick(4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
